// File: rtl/store_pkg.sv
// Shared helpers for the speculative store queue: derived widths and
// unpacking of the packed branch-success level remap table.
package store_pkg;

  localparam int unsigned MaxLvlBits = 8;
  localparam int unsigned TblIdxBits = 8;
  localparam int unsigned MaxTblBits = 1 << TblIdxBits;

  function automatic int unsigned spec_level_bits(input int unsigned spec_depth);
    return $clog2(spec_depth) + 1;
  endfunction

  function automatic int unsigned ptr_bits(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Extract entry idx (lvl_bits wide) from a zero-extended packed remap table.
  function automatic logic [MaxLvlBits-1:0] unpack_level(input logic [MaxTblBits-1:0] tbl,
                                                         input int unsigned idx,
                                                         input int unsigned lvl_bits);
    logic [MaxLvlBits-1:0] res;
    res = '0;
    for (int unsigned b = 0; b < MaxLvlBits; b++) begin
      if (b < lvl_bits) res[3'(b)] = tbl[TblIdxBits'(idx * lvl_bits + b)];
    end
    return res;
  endfunction

endpackage

// File: rtl/spec_store_queue_match.sv
// Finds the youngest set bit of a slot match vector in a circular buffer
// whose oldest entry sits at rptr_i; returns its absolute slot index.
module sq_youngest_match #(
  parameter int unsigned Depth  = 16,
  parameter int unsigned PtrBit = 4
) (
  input  logic [Depth-1:0]  match_i,
  input  logic [PtrBit-1:0] rptr_i,
  output logic              hit_o,
  output logic [PtrBit-1:0] slot_o
);

  logic [Depth-1:0]  rot;
  logic [PtrBit-1:0] youngest;

  // Rotate so bit 0 is the oldest entry; age then grows with index.
  always_comb begin
    rot = '0;
    for (int unsigned j = 0; j < Depth; j++) begin
      rot[j] = match_i[rptr_i + PtrBit'(j)];
    end
  end

  always_comb begin
    youngest = '0;
    for (int unsigned j = 0; j < Depth; j++) begin
      if (rot[j]) youngest = PtrBit'(j);
    end
  end

  assign hit_o  = |match_i;
  assign slot_o = rptr_i + youngest;

endmodule

// File: rtl/spec_store_queue.sv
// Speculative store queue: in-order store buffer tagged with speculation levels,
// released to memory at level 0, squashed on mispredict, forwards to loads.
module spec_store_queue
  import store_pkg::*;
#(
  parameter int unsigned INST_ID_BIT    = 8,
  parameter int unsigned ADDR_BIT       = 16,
  parameter int unsigned DATA_BIT       = 16,
  parameter int unsigned BUF_DEPTH      = 16,
  parameter int unsigned SPEC_DEPTH     = 4,
  parameter bit          FWD_EN         = 1'b1,
  parameter int unsigned SPEC_LEVEL_BIT = spec_level_bits(SPEC_DEPTH),
  parameter int unsigned PTR_BIT        = ptr_bits(BUF_DEPTH)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_vld,
  output logic                                    in_rdy,
  input  logic [INST_ID_BIT-1:0]                  in_id,
  input  logic [ADDR_BIT-1:0]                     in_addr,
  input  logic [DATA_BIT-1:0]                     in_data,
  input  logic [SPEC_LEVEL_BIT-1:0]               in_spec_level,
  output logic                                    out_vld,
  input  logic                                    out_rdy,
  output logic [INST_ID_BIT-1:0]                  out_id,
  output logic [ADDR_BIT-1:0]                     out_addr,
  output logic [DATA_BIT-1:0]                     out_data,
  input  logic                                    br_pred_vld,
  input  logic                                    br_pred_succ,
  input  logic [SPEC_LEVEL_BIT-1:0]               br_pred_fail_level,
  input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels,
  input  logic                                    ld_vld,
  input  logic [ADDR_BIT-1:0]                     ld_addr,
  output logic                                    ld_hit,
  output logic [DATA_BIT-1:0]                     ld_data,
  output logic [PTR_BIT:0]                        cnt,
  output logic                                    empty
);

  localparam int unsigned NumLvls = 1 << SPEC_LEVEL_BIT;
  localparam logic [PTR_BIT:0] DepthCnt = (PTR_BIT+1)'(BUF_DEPTH);

  logic [BUF_DEPTH-1:0]      vld_q, vld_d;
  logic [SPEC_LEVEL_BIT-1:0] lvl_q [BUF_DEPTH];
  logic [SPEC_LEVEL_BIT-1:0] lvl_d [BUF_DEPTH];
  logic [INST_ID_BIT-1:0]    id_q [BUF_DEPTH];
  logic [ADDR_BIT-1:0]       addr_q [BUF_DEPTH];
  logic [DATA_BIT-1:0]       data_q [BUF_DEPTH];
  logic [PTR_BIT-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PTR_BIT:0]          cnt_q, cnt_d;

  logic                      enq, commit, reclaim, deq;
  logic [MaxTblBits-1:0]     tbl_ext;
  logic [SPEC_LEVEL_BIT-1:0] lvl_map [NumLvls];

  assign in_rdy  = cnt_q < DepthCnt;
  assign enq     = in_vld && in_rdy;
  assign out_vld = vld_q[rptr_q] && (lvl_q[rptr_q] == '0);
  assign commit  = out_vld && out_rdy;
  // A dead head slot (squashed) is popped silently, one per cycle.
  assign reclaim = (cnt_q != '0) && !vld_q[rptr_q];
  assign deq     = commit || reclaim;

  assign out_id   = id_q[rptr_q];
  assign out_addr = addr_q[rptr_q];
  assign out_data = data_q[rptr_q];
  assign cnt      = cnt_q;
  assign empty    = (cnt_q == '0);

  assign tbl_ext = MaxTblBits'(br_pred_succ_nxt_levels);

  // Levels beyond the table cannot legally occur; map them to themselves.
  always_comb begin
    for (int unsigned k = 0; k < NumLvls; k++) begin
      if (k <= SPEC_DEPTH) begin
        lvl_map[k] = SPEC_LEVEL_BIT'(unpack_level(tbl_ext, k, SPEC_LEVEL_BIT));
      end else begin
        lvl_map[k] = SPEC_LEVEL_BIT'(k);
      end
    end
  end

  // Later assignments win: enqueue > commit > fail-squash.
  always_comb begin
    vld_d = vld_q;
    lvl_d = lvl_q;
    if (br_pred_vld) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (br_pred_succ) begin
          if (vld_q[i]) lvl_d[i] = lvl_map[lvl_q[i]];
        end else if (lvl_q[i] >= br_pred_fail_level) begin
          vld_d[i] = 1'b0;
        end
      end
    end
    if (commit) vld_d[rptr_q] = 1'b0;
    if (enq) begin
      vld_d[wptr_q] = 1'b1;
      lvl_d[wptr_q] = in_spec_level;
    end
  end

  always_comb begin
    rptr_d = deq ? rptr_q + 1'b1 : rptr_q;
    wptr_d = enq ? wptr_q + 1'b1 : wptr_q;
    cnt_d  = cnt_q + (PTR_BIT+1)'(enq) - (PTR_BIT+1)'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        lvl_q[i]  <= '0;
        id_q[i]   <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      lvl_q  <= lvl_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      if (enq) begin
        id_q[wptr_q]   <= in_id;
        addr_q[wptr_q] <= in_addr;
        data_q[wptr_q] <= in_data;
      end
    end
  end

  if (FWD_EN) begin : g_fwd
    logic [BUF_DEPTH-1:0] match;
    logic                 any_match;
    logic [PTR_BIT-1:0]   fwd_slot;

    always_comb begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        match[i] = vld_q[i] && (addr_q[i] == ld_addr);
      end
    end

    sq_youngest_match #(
      .Depth  (BUF_DEPTH),
      .PtrBit (PTR_BIT)
    ) u_youngest (
      .match_i (match),
      .rptr_i  (rptr_q),
      .hit_o   (any_match),
      .slot_o  (fwd_slot)
    );

    assign ld_hit  = ld_vld && any_match;
    assign ld_data = data_q[fwd_slot];
  end else begin : g_no_fwd
    assign ld_hit  = 1'b0;
    assign ld_data = '0;
  end

endmodule

// File: tb/tb_spec_store_queue.sv
// Self-checking bench for spec_store_queue: table-driven cycle vectors, a commit
// scoreboard, and hand-written fill/squash/wrap/reset sequences.
module tb_spec_store_queue;

  localparam int unsigned IdW = 8, AW = 16, DW = 16, Depth = 16, SpecDepth = 4;
  localparam int unsigned LvlW = 3, PtrW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_vld, in_rdy, out_vld, out_rdy;
  logic [IdW-1:0] in_id, out_id;
  logic [AW-1:0] in_addr, out_addr, ld_addr;
  logic [DW-1:0] in_data, out_data, ld_data;
  logic [LvlW-1:0] in_spec_level, br_pred_fail_level;
  logic br_pred_vld, br_pred_succ, ld_vld, ld_hit, empty;
  logic [LvlW*(SpecDepth+1)-1:0] br_pred_succ_nxt_levels;
  logic [PtrW:0] cnt;

  always #5 clk = ~clk;

  spec_store_queue #(
    .INST_ID_BIT (IdW),
    .ADDR_BIT    (AW),
    .DATA_BIT    (DW),
    .BUF_DEPTH   (Depth),
    .SPEC_DEPTH  (SpecDepth),
    .FWD_EN      (1'b1)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .in_vld                  (in_vld),
    .in_rdy                  (in_rdy),
    .in_id                   (in_id),
    .in_addr                 (in_addr),
    .in_data                 (in_data),
    .in_spec_level           (in_spec_level),
    .out_vld                 (out_vld),
    .out_rdy                 (out_rdy),
    .out_id                  (out_id),
    .out_addr                (out_addr),
    .out_data                (out_data),
    .br_pred_vld             (br_pred_vld),
    .br_pred_succ            (br_pred_succ),
    .br_pred_fail_level      (br_pred_fail_level),
    .br_pred_succ_nxt_levels (br_pred_succ_nxt_levels),
    .ld_vld                  (ld_vld),
    .ld_addr                 (ld_addr),
    .ld_hit                  (ld_hit),
    .ld_data                 (ld_data),
    .cnt                     (cnt),
    .empty                   (empty)
  );

  typedef struct {
    logic            in_vld;
    logic [AW-1:0]   in_addr;
    logic [DW-1:0]   in_data;
    logic [LvlW-1:0] in_lvl;
    logic            push;
    logic            out_rdy;
    logic            br_vld;
    logic            br_succ;
    logic [LvlW-1:0] fail_lvl;
    logic            ld_vld;
    logic [AW-1:0]   ld_addr;
    logic            exp_out_vld;
    int              exp_cnt;
    logic            exp_hit;
    logic [DW-1:0]   exp_ld_data;
  } vec_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } txn_t;

  vec_t vecs[$];
  txn_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [IdW-1:0] next_id;
  logic [PtrW-1:0] exp_wptr;

  function automatic vec_t mk(input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] idat,
                              input logic [LvlW-1:0] il, input logic push, input logic ordy,
                              input logic bv, input logic bs, input logic [LvlW-1:0] fl,
                              input logic lv, input logic [AW-1:0] la, input logic eov,
                              input int ecnt, input logic eh, input logic [DW-1:0] ed);
    vec_t v;
    v.in_vld = iv; v.in_addr = ia; v.in_data = idat; v.in_lvl = il; v.push = push;
    v.out_rdy = ordy; v.br_vld = bv; v.br_succ = bs; v.fail_lvl = fl;
    v.ld_vld = lv; v.ld_addr = la; v.exp_out_vld = eov; v.exp_cnt = ecnt;
    v.exp_hit = eh; v.exp_ld_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_vld = 1'b0; in_id = '0; in_addr = '0; in_data = '0; in_spec_level = '0;
    out_rdy = 1'b0; br_pred_vld = 1'b0; br_pred_succ = 1'b0; br_pred_fail_level = '0;
    ld_vld = 1'b0; ld_addr = '0;
  endtask

  // Only called where the bench knows the store will be accepted.
  task automatic enq_drive(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [LvlW-1:0] l, input logic push);
    in_vld = 1'b1; in_id = next_id; in_addr = a; in_data = d; in_spec_level = l;
    if (push) sb.push_back({next_id, a, d});
    next_id++;
    exp_wptr++;
  endtask

  task automatic step();
    txn_t got;
    @(negedge clk);
    if (rst_n && out_vld && out_rdy) begin
      got = {out_id, out_addr, out_data};
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got commit 0x%0h, required none", got);
      end else begin
        chk("sb_commit", 64'(got), 64'(sb.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    next_id = '0;
    exp_wptr = '0;
    // Success remap: every level drops by one, level 0 stays 0.
    br_pred_succ_nxt_levels = {3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    ld_vld = 1'b1;
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_ld_hit", 64'(ld_hit), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    vecs.push_back(mk(1, 16'h10, 16'hAA, 3'd0, 1, 1, 0, 0, 3'd0, 0, 16'h0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 1, 0, 0, 3'd0, 0, 16'h0, 1, 1, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 16'h0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'h20, 16'h11, 3'd1, 1, 0, 0, 0, 3'd0, 1, 16'h20, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'h20, 16'h22, 3'd2, 0, 0, 0, 0, 3'd0, 1, 16'h20, 0, 1, 1, 16'h11));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 16'h20, 0, 2, 1, 16'h22));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 0, 1, 0, 3'd2, 1, 16'h20, 0, 2, 1, 16'h22));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 16'h20, 0, 2, 1, 16'h11));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 16'h21, 0, 2, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 1, 1, 1, 3'd0, 0, 16'h0, 0, 2, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 1, 0, 0, 3'd0, 0, 16'h0, 1, 2, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 1, 0, 0, 3'd0, 0, 16'h0, 0, 1, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 16'h0, 0, 0, 0, 16'h0));

    foreach (vecs[r]) begin
      idle();
      if (vecs[r].in_vld) enq_drive(vecs[r].in_addr, vecs[r].in_data, vecs[r].in_lvl, vecs[r].push);
      out_rdy = vecs[r].out_rdy;
      br_pred_vld = vecs[r].br_vld;
      br_pred_succ = vecs[r].br_succ;
      br_pred_fail_level = vecs[r].fail_lvl;
      ld_vld = vecs[r].ld_vld;
      ld_addr = vecs[r].ld_addr;
      #1;
      chk($sformatf("vec%0d_out_vld", r), 64'(out_vld), 64'(vecs[r].exp_out_vld));
      chk($sformatf("vec%0d_cnt", r), 64'(cnt), 64'(vecs[r].exp_cnt));
      chk($sformatf("vec%0d_empty", r), 64'(empty), 64'(vecs[r].exp_cnt == 0));
      chk($sformatf("vec%0d_in_rdy", r), 64'(in_rdy), 64'(vecs[r].exp_cnt < 16));
      chk($sformatf("vec%0d_ld_hit", r), 64'(ld_hit), 64'(vecs[r].exp_hit));
      if (vecs[r].exp_hit) begin
        chk($sformatf("vec%0d_ld_data", r), 64'(ld_data), 64'(vecs[r].exp_ld_data));
      end
      step();
    end

    // Fill with speculative stores, then resolve and drain.
    for (int i = 0; i < 16; i++) begin
      idle();
      enq_drive(16'h100 + 16'(i), 16'h5000 + 16'(i), 3'd1, 1'b1);
      step();
    end
    idle();
    in_vld = 1'b1; in_addr = 16'hDEAD; in_data = 16'hBEEF;
    #1;
    chk("full_in_rdy", 64'(in_rdy), 64'd0);
    chk("full_cnt", 64'(cnt), 64'd16);
    chk("full_out_vld", 64'(out_vld), 64'd0);
    step();
    idle();
    br_pred_vld = 1'b1; br_pred_succ = 1'b1;
    #1;
    chk("full_reject_cnt", 64'(cnt), 64'd16);
    step();
    idle();
    out_rdy = 1'b1;
    #1;
    chk("remap_out_vld", 64'(out_vld), 64'd1);
    chk("full_commit_in_rdy", 64'(in_rdy), 64'd0);
    begin
      int drained;
      drained = 0;
      for (int c = 0; c < 16; c++) begin
        idle();
        out_rdy = 1'b1;
        #1;
        if (out_vld) drained++;
        step();
      end
      chk("drain_count", 64'(drained), 64'd16);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Levels 0,1,2 then fail at level 1.
    idle(); enq_drive(16'h200, 16'hA0, 3'd0, 1'b1); step();
    idle(); enq_drive(16'h201, 16'hA1, 3'd1, 1'b0); step();
    idle(); enq_drive(16'h202, 16'hA2, 3'd2, 1'b0); step();
    idle();
    br_pred_vld = 1'b1; br_pred_fail_level = 3'd1; out_rdy = 1'b1;
    #1;
    chk("sq_head_vld", 64'(out_vld), 64'd1);
    chk("sq_cnt3", 64'(cnt), 64'd3);
    step();
    idle(); out_rdy = 1'b1; #1;
    chk("sq_out_vld", 64'(out_vld), 64'd0);
    chk("sq_cnt2", 64'(cnt), 64'd2);
    step();
    idle(); #1;
    chk("sq_cnt1", 64'(cnt), 64'd1);
    step();
    chk("sq_empty", 64'(empty), 64'd1);

    // Squash of the head itself.
    idle(); enq_drive(16'h300, 16'hB0, 3'd0, 1'b0); step();
    idle(); #1;
    chk("hs_out_vld", 64'(out_vld), 64'd1);
    br_pred_vld = 1'b1; br_pred_fail_level = 3'd0;
    step();
    idle(); #1;
    chk("hs_drop", 64'(out_vld), 64'd0);
    step();
    chk("hs_empty", 64'(empty), 64'd1);

    // Walk pointers to slot 14, then forward across the wrap.
    for (int g = 0; g < 2 * Depth && exp_wptr != 4'd14; g++) begin
      idle();
      enq_drive(16'h400, 16'hC0 + 16'(g), 3'd0, 1'b1);
      out_rdy = 1'b1;
      step();
    end
    idle(); out_rdy = 1'b1; step();
    chk("wrap_ptr", 64'(exp_wptr), 64'd14);
    chk("wrap_pre_empty", 64'(empty), 64'd1);
    for (int k = 0; k < 3; k++) begin
      idle();
      enq_drive(16'h30, 16'hD1 + 16'(k), 3'd1, 1'b0);
      step();
    end
    idle(); ld_vld = 1'b1; ld_addr = 16'h30; #1;
    chk("wrap_hit", 64'(ld_hit), 64'd1);
    chk("wrap_data", 64'(ld_data), 64'hD3);
    chk("wrap_cnt", 64'(cnt), 64'd3);
    br_pred_vld = 1'b1; br_pred_fail_level = 3'd1;
    step();
    idle(); ld_vld = 1'b1; ld_addr = 16'h30; #1;
    chk("wrap_sq_hit", 64'(ld_hit), 64'd0);
    begin
      int budget;
      budget = 0;
      while (!empty && budget < 8) begin
        step();
        budget++;
      end
      chk("wrap_reclaim_cycles", 64'(budget), 64'd3);
    end
    chk("wrap_empty", 64'(empty), 64'd1);

    // Asynchronous reset in the middle of a drain.
    for (int k = 0; k < 6; k++) begin
      idle();
      enq_drive(16'h500 + 16'(k), 16'hE0 + 16'(k), 3'd0, k == 0);
      step();
    end
    idle(); out_rdy = 1'b1; step();
    idle(); out_rdy = 1'b1; ld_vld = 1'b1; ld_addr = 16'h503; #1;
    chk("mid_cnt", 64'(cnt), 64'd5);
    chk("mid_hit", 64'(ld_hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("mid_rst_ld_hit", 64'(ld_hit), 64'd0);
    chk("mid_rst_cnt", 64'(cnt), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", 64'(empty), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spec_store_queue.md
# spec_store_queue

Parametrised successor to the speculative store buffer. Holds committed-in-order memory write requests tagged with a speculation level, releases them to memory only once non-speculative, squashes them on branch mispredict and forwards the youngest matching store data to loads. Sits between the store FU / load FU and the data-memory write port.

## Interface
- INST_ID_BIT, 8, instruction id width
- ADDR_BIT, 16, address width
- DATA_BIT, 16, data width
- BUF_DEPTH, 16, entries; power of two, ≥2
- SPEC_DEPTH, 4, max outstanding branches
- FWD_EN, 1, 1 = load-forwarding logic present; 0 = ld_hit tied 0
- SPEC_LEVEL_BIT, $clog2(SPEC_DEPTH)+1, derived
- PTR_BIT, $clog2(BUF_DEPTH), derived
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_vld / in_rdy  in/out  1  store enqueue handshake
- in_id, in_addr, in_data, in_spec_level  in  INST_ID_BIT/ADDR_BIT/DATA_BIT/SPEC_LEVEL_BIT  store payload
- out_vld / out_rdy  out/in  1  memory commit handshake
- out_id, out_addr, out_data  out  as above  head entry payload
- br_pred_vld, br_pred_succ  in  1  branch resolution
- br_pred_fail_level  in  SPEC_LEVEL_BIT  squash entries with level ≥ this
- br_pred_succ_nxt_levels  in  SPEC_LEVEL_BIT*(SPEC_DEPTH+1)  packed remap table, index = old level
- ld_vld  in  1  forwarding query valid
- ld_addr  in  ADDR_BIT  query address
- ld_hit  out  1  matching live store exists
- ld_data  out  DATA_BIT  data of youngest matching store
- cnt  out  PTR_BIT+1  occupied slots (incl. squashed, not yet reclaimed)
- empty  out  1  cnt == 0

## Operation
- Circular buffer, rptr/wptr, per-entry vld, id, addr, data, spec_level.
- Enqueue when in_vld && in_rdy: slot wptr written with payload, vld=1; in_rdy = cnt < BUF_DEPTH. Upstream presents in_spec_level already remapped/filtered for a same-cycle resolution.
- Branch success: every vld entry's level ← nxt_levels[level]. Branch fail: every entry with level ≥ fail_level → vld=0 (data retained, slot still counted).
- out_vld = vld[rptr] && level[rptr] == 0; payload always head slot.
- Commit (out_vld && out_rdy): vld[rptr]=0, rptr+1, cnt−1.
- Reclaim: cnt>0 && !vld[rptr] → rptr+1, cnt−1 (one slot/cycle).
- cnt next = cnt + enq − (commit | reclaim); commit and reclaim mutually exclusive.
- Forward: over vld entries with addr == ld_addr, pick youngest (max distance from rptr, wrap-aware); ld_hit = ld_vld && match && FWD_EN. Combinational. Squashed entries never forward. Same-cycle enqueue not visible.
- Precedence per slot: enqueue > commit > fail-squash.

## Timing
- Reset: out_vld=0, in_rdy=1, ld_hit=0, cnt=0, empty=1, rptr=wptr=0, all vld=0.
- Enqueue→out_vld: 1 cycle minimum (level 0, buffer empty).
- Enqueue→forwardable: next cycle.
- Branch update effective next cycle; a fail squashing the head drops out_vld next cycle.
- Full: in_rdy=0; a simultaneous commit does not raise in_rdy same cycle.
- Pointer wrap at BUF_DEPTH−1→0; full distinguished by cnt.
- Reset mid-operation discards all entries immediately.

## Structure
- Package store_pkg: spec-level width function, ptr width, remap-table unpack helper.
- Sub-module sq_youngest_match: rotate match vector by rptr, priority-encode highest index, return slot; reusable by a future load queue.

## Test plan
- Enqueue addr 0x10 data 0xAA level 0, out_rdy=1 → out_vld next cycle, out_addr 0x10, cnt 1→0.
- Fill 16 entries level 1 → in_rdy=0, cnt=16; branch succ remap 1→0 → out_vld next cycle, drain 16 in 16 cycles.
- Entries at levels 0,1,2; fail level 1 → entries 2,3 squashed, head commits, then 2 reclaim cycles, empty=1.
- Stores 0x20←0x11 then 0x20←0x22; ld_addr 0x20 → ld_hit=1, ld_data 0x22; after squash of second, ld_data 0x11.
- Wrap: rptr=14, stores at slots 14,15,0 to same addr → youngest (slot 0) forwarded.
- Assert rst_n mid-drain with cnt=5 → all outputs to reset values immediately.
